// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int          FETCH_FIFO_DEPTH = 2;
    localparam int          CNT_W            = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam int          PTR_W            = $clog2(FETCH_FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle: icache read port, redirect input and decode handshake.
// Latency: none (wires only).
// Backpressure: decode stalls via instrReady; the cache port has none.
interface ifetch_unit_if;

    logic [31:0] iCacheReadAddr;
    logic [31:0] iCacheReadData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic [31:0] instrData;
    logic [31:0] instrPc;
    logic        instrReady;

    // master is the fetch unit, slave is the cache/redirect/decode environment
    modport master (
        output iCacheReadAddr,
        input  iCacheReadData,
        input  redirectValid,
        input  redirectPc,
        output instrValid,
        output instrData,
        output instrPc,
        input  instrReady
    );

    modport slave (
        input  iCacheReadAddr,
        output iCacheReadData,
        output redirectValid,
        output redirectPc,
        input  instrValid,
        input  instrData,
        input  instrPc,
        output instrReady
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, instr} buffer absorbing the icache's 1-cycle read latency.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: none internally; the issuer guarantees no push when full.
module fetch_skid_fifo
    import ifetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t           mem [FETCH_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (count == CNT_W'(FETCH_FIFO_DEPTH))));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues word-aligned icache reads and hands words to decode.
// Latency: issue to instrValid is 2 cycles; redirect target valid 2 cycles later.
// Backpressure: instrReady low buffers up to 2 words, then issue stalls.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);

    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      fetch_pc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_dat;
    logic             push;
    logic             pop;
    logic             issue;
    logic [OCC_W-1:0] occ;

    assign bus.iCacheReadAddr = bus.redirectValid ? word_align(bus.redirectPc) : fetch_pc;

    // A redirect hides the stale head and squashes the response arriving now.
    assign bus.instrValid = (fifo_count != '0) & ~bus.redirectValid;
    assign pop            = bus.instrValid & bus.instrReady;
    assign push           = inflight & ~bus.redirectValid;

    // Occupancy after this cycle's pop, counting the request still in the cache.
    assign occ   = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue = bus.redirectValid | (occ < OCC_W'(FETCH_FIFO_DEPTH));

    assign push_dat.pc    = inflight_pc;
    assign push_dat.instr = bus.iCacheReadData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            fetch_pc    <= bus.iCacheReadAddr + PC_STEP;
            inflight    <= 1'b1;
            inflight_pc <= bus.iCacheReadAddr;
        end else begin
            inflight    <= 1'b0;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (bus.redirectValid),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    assign bus.instrData = fifo_head.instr;
    assign bus.instrPc   = fifo_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed vector bench for ifetch_unit: stream, stall, redirects, wrap, async reset.
// Two DUTs share clock/reset: one from PC 0, one from PC 0xFFFF_FFF8.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ifetch_unit_if bus  ();
    ifetch_unit_if wbus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    // Cache models: registered read, data = addr ^ key.
    always @(posedge clk) bus.iCacheReadData  <= bus.iCacheReadAddr  ^ XOR_KEY;
    always @(posedge clk) wbus.iCacheReadData <= wbus.iCacheReadAddr ^ XOR_KEY;

    typedef struct {
        logic        rdy;
        logic        rvld;
        logic [31:0] rpc;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [1:0]  cnt;
        logic        chk_w;
        logic        w_vld;
        logic [31:0] w_pc;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rdy, input logic rvld, input logic [31:0] rpc,
                                input logic vld, input logic [31:0] pc, input logic [31:0] addr,
                                input logic [1:0] cnt, input logic chk_w, input logic w_vld,
                                input logic [31:0] w_pc);
        vec_t v;
        v.rdy = rdy; v.rvld = rvld; v.rpc = rpc; v.vld = vld; v.pc = pc;
        v.addr = addr; v.cnt = cnt; v.chk_w = chk_w; v.w_vld = w_vld; v.w_pc = w_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each vector starts 1 time unit after a rising edge and covers one cycle.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.instrReady    = vecs[i].rdy;
            bus.redirectValid = vecs[i].rvld;
            bus.redirectPc    = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d valid", i), {31'b0, bus.instrValid}, {31'b0, vecs[i].vld});
            chk($sformatf("v%0d addr", i), bus.iCacheReadAddr, vecs[i].addr);
            chk($sformatf("v%0d count", i), {30'b0, dut.fifo_count}, {30'b0, vecs[i].cnt});
            if (vecs[i].vld) begin
                chk($sformatf("v%0d pc", i), bus.instrPc, vecs[i].pc);
                chk($sformatf("v%0d data", i), bus.instrData, vecs[i].pc ^ XOR_KEY);
            end
            if (vecs[i].chk_w) begin
                chk($sformatf("v%0d wrap valid", i), {31'b0, wbus.instrValid}, {31'b0, vecs[i].w_vld});
                if (vecs[i].w_vld) begin
                    chk($sformatf("v%0d wrap pc", i), wbus.instrPc, vecs[i].w_pc);
                    chk($sformatf("v%0d wrap data", i), wbus.instrData, vecs[i].w_pc ^ XOR_KEY);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.instrReady     = 1'b1;
        bus.redirectValid  = 1'b0;
        bus.redirectPc     = '0;
        wbus.instrReady    = 1'b1;
        wbus.redirectValid = 1'b0;
        wbus.redirectPc    = '0;

        //          rdy  rv   rpc           vld  pc            addr          cnt chk_w w_vld w_pc
        // stream from reset (0..5), with the wrapping DUT alongside
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h00,  0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h04,  0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h00,  32'h08,  1, 1, 1, 32'hFFFF_FFF8));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h04,  32'h0C,  1, 1, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h08,  32'h10,  1, 1, 1, 32'h0000_0000));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h0C,  32'h14,  1, 1, 1, 32'h0000_0004));
        // decode stalls for 5 cycles (6..10), then releases
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h10,  32'h18,  1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h10,  32'h18,  2, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h10,  32'h18,  2, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h10,  32'h18,  2, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h10,  32'h18,  2, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h10,  32'h18,  2, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h14,  32'h1C,  1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h18,  32'h20,  1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h1C,  32'h24,  1, 0, 0, 32'h0));
        // fill to 2 entries, then redirect to 0x103 (aligned to 0x100)
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h20,  32'h28,  1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h20,  32'h28,  2, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h103, 0, 32'h0,   32'h100, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,   32'h104, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h100, 32'h108, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h104, 32'h10C, 1, 0, 0, 32'h0));
        // redirect to 0x202 while stalled with a response in flight
        vecs.push_back(mk(0, 1, 32'h202, 0, 32'h0,   32'h200, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   32'h204, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h200, 32'h208, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h200, 32'h208, 2, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h204, 32'h20C, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h208, 32'h210, 1, 0, 0, 32'h0));

        // power-on reset values
        #2 rst_n = 1'b0;
        #1;
        chk("reset valid", {31'b0, bus.instrValid}, 32'h0);
        chk("reset data", bus.instrData, 32'h0);
        chk("reset pc", bus.instrPc, 32'h0);
        chk("reset addr", bus.iCacheReadAddr, 32'h0);
        chk("reset wrap addr", wbus.iCacheReadAddr, 32'hFFFF_FFF8);
        chk("reset wrap valid", {31'b0, wbus.instrValid}, 32'h0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vecs(0, vecs.size() - 1);

        // asynchronous reset between edges while both DUTs are streaming
        #3 rst_n = 1'b0;
        #1;
        chk("midreset valid", {31'b0, bus.instrValid}, 32'h0);
        chk("midreset data", bus.instrData, 32'h0);
        chk("midreset pc", bus.instrPc, 32'h0);
        chk("midreset addr", bus.iCacheReadAddr, 32'h0);
        chk("midreset wrap valid", {31'b0, wbus.instrValid}, 32'h0);
        chk("midreset wrap data", wbus.instrData, 32'h0);
        chk("midreset wrap pc", wbus.instrPc, 32'h0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vecs(0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit. Generates word-aligned fetch addresses into the instruction cache read port, captures the returned instruction words one cycle later, and presents them to decode via a valid/ready handshake. It sits between the PC/redirect logic and the decode stage, and is the requester side of the `iCacheReadAddr`/`iCacheReadData` interface. A 2-entry buffer absorbs the cache's fixed 1-cycle read latency, so decode back-pressure never loses an instruction.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset. Must be word-aligned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `iCacheReadAddr` out 32: byte fetch address to the cache. Bits [1:0] are always 0.
- `iCacheReadData` in 32: cache data. It is registered in the cache and valid the cycle after its address was presented.
- `redirectValid` in 1: branch/jump redirect strobe, 1 cycle.
- `redirectPc` in 32: redirect target. Bits [1:0] are ignored and treated as 0.
- `instrValid` out 1: an instruction is available to decode.
- `instrData` out 32: instruction word.
- `instrPc` out 32: byte address of `instrData`.
- `instrReady` in 1: decode accepts. A transfer (pop) occurs when `instrValid & instrReady`.

## Operation
- **State:**
  - `fetchPc` (32) holds the next address to issue.
  - `inflight` (1) is set when a request was issued last cycle.
  - `inflightPc` (32) is the address of that request.
  - A 2-entry FIFO of {pc, instr} entries, with `count` 0..2.
- **Issue rule:** a request is issued in a cycle when `count + inflight - pop < 2`, or when `redirectValid` is high.
  - On issue: `inflight <= 1`, `inflightPc <= iCacheReadAddr`, `fetchPc <= iCacheReadAddr + 4`.
  - With no issue: `inflight <= 0` and `fetchPc` holds.
- **Address mux:** `iCacheReadAddr = redirectValid ? {redirectPc[31:2],2'b00} : fetchPc`. This path is combinational.
- **Capture:** when `inflight` is set and `redirectValid` is low, push {`inflightPc`, `iCacheReadData`} into the FIFO.
- **Output:** `instrValid = (count != 0) & ~redirectValid`. `instrData` and `instrPc` show the FIFO head.
- **Redirect (cycle N):**
  - FIFO is flushed (`count <= 0`).
  - The response arriving in N is discarded.
  - No pop occurs in N, even if `instrReady` is high.
  - `redirectPc` is issued in N.
- **Simultaneous events:**
  - Push and pop in the same cycle leave `count` unchanged.
  - Redirect overrides both push and pop.
- **Overflow:** by construction the FIFO never overflows. An implementation assertion checks that no push occurs when `count == 2` without a pop.
- **Wrap:** `fetchPc` is 32-bit modulo, so `32'hFFFF_FFFC + 4 = 32'h0000_0000`.

## Timing
- **Reset (asynchronous, while `rst_n == 0`):**
  - `fetchPc = RESET_PC`, `inflight = 0`, `count = 0`, `inflightPc = 0`.
  - `instrValid = 0`, `instrData = 0`, `instrPc = 0`.
  - `iCacheReadAddr = RESET_PC`.
- **Start-up:** first issue happens in cycle 0 after deassertion. First `instrValid` is in cycle 2.
- **Latency:** issue to `instrValid` is 2 cycles. `redirectValid` in N gives the target on `instrValid` in N+2.
- **Throughput:** with `instrReady` held high, one instruction per cycle and no bubbles.
- **Back-pressure:** when `instrReady` drops, at most 2 words are buffered and issue stalls. Head data stays stable while `instrValid & ~instrReady`.
- **Reset mid-operation:** all state returns to reset values immediately. Any in-flight response is ignored because `inflight = 0`.

## Structure
- **`ifetch_pkg`:** contains `PC_STEP = 4`, `typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t`, and the `FETCH_FIFO_DEPTH = 2` constant.
- **Sub-module `fetch_skid_fifo`:**
  - 2-entry FIFO of `fetch_entry_t`.
  - Ports: `push`, `pop`, `flush`, `count`, `head`.
  - Asynchronous active-low reset.
- **`ifetch_unit`:** holds the PC/issue logic, in-flight tracking and the redirect mux.

## Test plan
- **Reset/stream:** `RESET_PC=0`, cache model returns `addr^32'hA5A5_0000`, `instrReady=1`. Expect `instrValid` from cycle 2 with `instrPc` = 0, 4, 8, 12, … on consecutive cycles and matching data.
- **Back-pressure:** hold `instrReady=0` for 5 cycles mid-stream. Expect `count` to reach 2, `iCacheReadAddr` to hold, and no PC skipped or duplicated after release (e.g. 0x10, 0x14, 0x18).
- **Redirect:** assert `redirectValid` with `redirectPc=32'h0000_0103` while 2 entries are buffered. Expect `iCacheReadAddr=0x100` that cycle, `instrValid=0` for 2 cycles, then `instrPc` = 0x100, 0x104.
- **Redirect during stall:** redirect with `instrReady=0` and an in-flight response. Expect stale data never presented and the first valid `instrPc` equal to the target.
- **Wrap:** `RESET_PC=32'hFFFF_FFF8`. Expect `instrPc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Async reset mid-stream:** pull `rst_n` low between clock edges. Expect `instrValid`, `instrData` and `instrPc` to go to 0 immediately, and the restart sequence to match scenario 1.
